// File: rtl/apb_mem_bridge_pkg.sv
// Shared definitions for the APB-to-synchronous-memory bridge.
//   state_t              : bridge FSM states
//   *_DEFAULT            : default widths (memory address, memory data, APB data)
//   addr_misaligned()    : true when a byte address is not word aligned
package mem_bridge_pkg;

    localparam int MEM_AW_DEFAULT = 8;
    localparam int MEM_DW_DEFAULT = 21;
    localparam int APB_DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    function automatic logic addr_misaligned(input logic [1:0] byte_lsbs);
        return byte_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/apb_mem_bridge_if.sv
// APB completer-side bus bundle.
//   ADDR_W : byte address width (memory word address width + 2)
//   DATA_W : APB data width
//   master : drives psel/penable/pwrite/paddr/pwdata, observes prdata/pready/pslverr
//   slave  : the reverse view, used by the bridge
interface apb_mem_bridge_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_mem_bridge.sv
// APB completer that turns each transfer into a single access on a
// synchronous memory (one-cycle read latency, read has priority over write).
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   apb          : APB slave bundle (psel, penable, pwrite, paddr, pwdata,
//                  prdata, pready, pslverr)
//   mem_ce       : memory chip enable, one cycle per aligned transfer
//   mem_wren     : memory write enable
//   mem_rden     : memory read enable
//   mem_addr     : memory word address (byte address >> 2)
//   mem_wr_data  : memory write data (low MEM_DW bits of pwdata)
//   mem_rd_data  : memory read data, valid the cycle after a read enable
// Latency from setup cycle to pready: write 3, read 4, misaligned 2.
module apb_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEFAULT,
    parameter int MEM_DW = MEM_DW_DEFAULT,
    parameter int APB_DW = APB_DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    apb_mem_bridge_if.slave   apb,
    output logic              mem_ce,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wr_data,
    input  logic [MEM_DW-1:0] mem_rd_data
);

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic                ce_q, ce_d;
    logic                wren_q, wren_d;
    logic                rden_q, rden_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [APB_DW-1:0]   prdata_q, prdata_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [MEM_DW-1:0]   wdata_q, wdata_d;
    logic [APB_DW-1:0]   rd_ext;

    // Upper write-data bits are intentionally dropped by the memory path.
    logic unused_pwdata;
    assign unused_pwdata = ^apb.pwdata;

    always_comb begin
        rd_ext = '0;
        rd_ext[MEM_DW-1:0] = mem_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            ce_q      <= 1'b0;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            ce_q      <= ce_d;
            wren_q    <= wren_d;
            rden_q    <= rden_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Outputs are registered, so each branch sets the values the outputs
    // must take in the *next* state.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        ce_d      = 1'b0;
        wren_d    = 1'b0;
        rden_d    = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    write_d = apb.pwrite;
                    if (addr_misaligned(apb.paddr[1:0])) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                    end else begin
                        state_d = ISSUE;
                        ce_d    = 1'b1;
                        wren_d  = apb.pwrite;
                        rden_d  = !apb.pwrite;
                        addr_d  = apb.paddr[MEM_AW+1:2];
                        wdata_d = apb.pwdata[MEM_DW-1:0];
                    end
                end
            end
            ISSUE: begin
                if (write_q) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                prdata_d = rd_ext;
                state_d  = RESP;
                pready_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_ce      = ce_q;
    assign mem_wren    = wren_q;
    assign mem_rden    = rden_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Self-checking bench for apb_mem_bridge: a behavioural memory beside the
// DUT, and a word-array reference model predicting latency, error, read data
// and final memory contents for directed and random APB transfers.
module tb_apb_mem_bridge;

    localparam int AW = 8;
    localparam int DW = 21;
    localparam int PW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_mem_bridge_if #(.ADDR_W(AW+2), .DATA_W(PW)) apb ();

    logic          mem_ce;
    logic          mem_wren;
    logic          mem_rden;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;

    apb_mem_bridge #(.MEM_AW(AW), .MEM_DW(DW), .APB_DW(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .apb         (apb),
        .mem_ce      (mem_ce),
        .mem_wren    (mem_wren),
        .mem_rden    (mem_rden),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    // Synchronous memory attached to the bridge: read has priority.
    logic [DW-1:0] mem_arr [0:255];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_rden)
                mem_rd_data <= mem_arr[mem_addr];
            else if (mem_wren)
                mem_arr[mem_addr] <= mem_wr_data;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:255];
    logic [PW-1:0] ref_prdata;

    int n_checks = 0;
    int n_errors = 0;
    bit skip_sync = 1'b0;
    bit drop_psel = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            // An access-phase pattern while idle must not start anything.
            if ($urandom_range(0, 1) == 1) begin
                apb.psel    = 1'b1;
                apb.penable = 1'b1;
                apb.pwrite  = 1'($urandom_range(0, 1));
                apb.paddr   = 10'($urandom);
                apb.pwdata  = $urandom;
            end else begin
                apb.psel    = 1'b0;
                apb.penable = 1'b0;
            end
            @(negedge clk);
            check_eq("idle_quiet", {30'd0, mem_ce, apb.pready}, 32'd0);
        end
    endtask

    task automatic xfer(input bit wr, input logic [9:0] addr, input logic [31:0] data);
        bit            err;
        int            exp_lat;
        int            cyc;
        int            ce_cnt;
        int            strays;
        bit            got;
        bit            both;
        logic [AW-1:0] ce_addr;
        logic          ce_wren;
        logic          ce_rden;
        logic [DW-1:0] ce_wdata;
        logic          err_seen;
        logic [31:0]   rd_seen;
        logic [7:0]    idx;

        idx     = addr[9:2];
        err     = (addr[1:0] != 2'b00);
        exp_lat = err ? 2 : (wr ? 3 : 4);
        if (err)
            ref_prdata = '0;
        else if (wr)
            ref_mem[idx] = data[DW-1:0];
        else
            ref_prdata = 32'(ref_mem[idx]);

        if (!skip_sync) begin
            @(posedge clk);
            #1;
        end
        skip_sync   = 1'b0;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = data;

        cyc = 0; ce_cnt = 0; strays = 0; got = 1'b0; both = 1'b0;
        ce_addr = '0; ce_wren = 1'b0; ce_rden = 1'b0; ce_wdata = '0;
        err_seen = 1'b0; rd_seen = '0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (mem_ce) begin
                ce_cnt++;
                ce_addr  = mem_addr;
                ce_wren  = mem_wren;
                ce_rden  = mem_rden;
                ce_wdata = mem_wr_data;
            end else if (mem_wren || mem_rden) begin
                strays++;
            end
            if (mem_wren && mem_rden)
                both = 1'b1;
            if (apb.pready) begin
                got      = 1'b1;
                err_seen = apb.pslverr;
                rd_seen  = apb.prdata;
            end else begin
                if (apb.pslverr)
                    strays++;
                @(posedge clk);
                #1;
                if (drop_psel) begin
                    apb.psel    = 1'b0;
                    apb.penable = 1'b0;
                end else begin
                    apb.penable = 1'b1;
                end
            end
        end

        check_eq("latency", got ? cyc : 99, exp_lat);
        check_eq("pslverr", {31'd0, err_seen}, {31'd0, err});
        check_eq("prdata", rd_seen, ref_prdata);
        check_eq("ce_count", ce_cnt, err ? 0 : 1);
        check_eq("stray_enables", strays, 0);
        check_eq("wren_rden_both", {31'd0, both}, 32'd0);
        if (!err) begin
            check_eq("mem_addr", {24'd0, ce_addr}, {24'd0, idx});
            check_eq("mem_wren", {31'd0, ce_wren}, {31'd0, wr});
            check_eq("mem_rden", {31'd0, ce_rden}, {31'd0, !wr});
            if (wr)
                check_eq("mem_wr_data", {11'd0, ce_wdata}, {11'd0, data[DW-1:0]});
        end
    endtask

    initial begin
        int mism;
        logic [9:0] a;

        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0;
        mem_rd_data = '0;
        ref_prdata  = '0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = DW'($urandom);
            ref_mem[i] = mem_arr[i];
        end

        #12;
        check_eq("rst_ce",     {29'd0, mem_ce, mem_wren, mem_rden}, 32'd0);
        check_eq("rst_resp",   {30'd0, apb.pready, apb.pslverr}, 32'd0);
        check_eq("rst_prdata", apb.prdata, 32'd0);
        check_eq("rst_addr",   {24'd0, mem_addr}, 32'd0);
        check_eq("rst_wdata",  {11'd0, mem_wr_data}, 32'd0);

        // Setup presented together with reset release: first edge must take it.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        skip_sync = 1'b1;
        xfer(1'b1, 10'h010, 32'hFFE1_2345);
        idle(1);
        xfer(1'b0, 10'h010, 32'h0);
        check_eq("readback_0x010", apb.prdata, 32'h0001_2345);
        idle(1);
        xfer(1'b1, 10'h3FE, 32'h1234_5678);
        check_eq("word_ff_unchanged", {11'd0, mem_arr[255]}, {11'd0, ref_mem[255]});

        // Back-to-back, no idle gap
        idle(1);
        xfer(1'b1, 10'h0FC, 32'h001F_FFFF);
        xfer(1'b0, 10'h0FC, 32'h0);
        check_eq("b2b_read", apb.prdata, 32'h001F_FFFF);
        xfer(1'b1, 10'h000, 32'h0);

        // psel withdrawn after setup: transfer still completes
        idle(1);
        drop_psel = 1'b1;
        xfer(1'b0, 10'h010, 32'h0);
        drop_psel = 1'b0;
        idle(1);

        // Reset pulsed during ISSUE of a write to 0x020
        @(posedge clk);
        #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = 10'h020; apb.pwdata = 32'h000A_BCDE ^ 32'(ref_mem[8]);
        @(posedge clk);
        #1;
        apb.penable = 1'b1;
        check_eq("issue_ce", {31'd0, mem_ce}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_ce", {29'd0, mem_ce, mem_wren, mem_rden}, 32'd0);
        check_eq("async_rst_resp", {30'd0, apb.pready, apb.pslverr}, 32'd0);
        check_eq("async_rst_prdata", apb.prdata, 32'd0);
        check_eq("async_rst_addr", {24'd0, mem_addr}, 32'd0);
        ref_prdata = '0;
        apb.psel = 1'b0; apb.penable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_word_unchanged", {11'd0, mem_arr[8]}, {11'd0, ref_mem[8]});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        skip_sync = 1'b1;
        xfer(1'b0, 10'h020, 32'h0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            a = {8'($urandom), 2'b00};
            if ($urandom_range(0, 4) == 0)
                a[1:0] = 2'($urandom_range(1, 3));
            xfer(1'($urandom_range(0, 1)), a, $urandom);
            idle($urandom_range(0, 2));
        end

        mism = 0;
        for (int i = 0; i < 256; i++)
            if (mem_arr[i] !== ref_mem[i])
                mism++;
        check_eq("final_mem_mismatches", mism, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
